// File: rtl/approx_mul16_err_monitor.sv
`default_nettype none
// ============================================================================
// approx_mul16_err_monitor: error-distance statistics for a 16x16 approx mult
// Revision: 1.0
// ============================================================================
module approx_mul16_err_monitor #(
  parameter int CNT_W = 16,
  parameter int SUM_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [31:0]      in_prod,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum_ed,
  output logic [31:0]      max_ed,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain_q, drain_d;
  logic             v1_q, v1_d;
  logic [31:0]      ex_q, ex_d;
  logic [31:0]      ap_q, ap_d;
  logic             v2_q, v2_d;
  logic [31:0]      ed_q, ed_d;
  logic             nz_q, nz_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [31:0]      max_q, max_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic             accept;
  logic [CNT_W-1:0] cnt_inc;
  logic [SUM_W:0]   sum_ext;

  assign in_ready = (state_q == S_RUN) && (cnt_q < len_q);
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = cnt_q + 1'b1;
  // The carry out of the widened sum flags saturation; a saturated sum
  // carries on any nonzero ED, so it stays pinned at all-ones.
  assign sum_ext  = {1'b0, sum_q} + {{(SUM_W-31){1'b0}}, ed_q};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    v1_d    = accept;
    ex_d    = {16'd0, in_a} * {16'd0, in_b};
    ap_d    = in_prod;
    v2_d    = v1_q;
    ed_d    = (ex_q >= ap_q) ? (ex_q - ap_q) : (ap_q - ex_q);
    nz_d    = (ed_d != 32'd0);
    sum_d   = sum_q;
    max_d   = max_q;
    err_d   = err_q;

    if (v2_q) begin
      sum_d = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
      max_d = (ed_q > max_q) ? ed_q : max_q;
      err_d = err_q + {{(CNT_W-1){1'b0}}, nz_q};
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          len_d   = cfg_len;
          cnt_d   = '0;
          sum_d   = '0;
          max_d   = '0;
          err_d   = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_DRAIN;
            drain_d = 1'b0;
          end
        end else if (cnt_q >= len_q) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end
      end
      S_DRAIN: begin
        // Two drain cycles let the last sample clear both pipeline stages.
        if (drain_q) state_d = S_DONE;
        drain_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      v1_q    <= 1'b0;
      ex_q    <= '0;
      ap_q    <= '0;
      v2_q    <= 1'b0;
      ed_q    <= '0;
      nz_q    <= 1'b0;
      sum_q   <= '0;
      max_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      v1_q    <= v1_d;
      ex_q    <= ex_d;
      ap_q    <= ap_d;
      v2_q    <= v2_d;
      ed_q    <= ed_d;
      nz_q    <= nz_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      err_q   <= err_d;
    end
  end

  assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign sum_ed       = sum_q;
  assign max_ed       = max_q;
  assign err_count    = err_q;
  assign sample_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_mul16_err_monitor.sv
`default_nettype none
// ============================================================================
// tb_approx_mul16_err_monitor: directed bench for the ED statistics monitor
// Revision: 1.0
// ============================================================================
module tb_approx_mul16_err_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cfg_len;
  logic        in_valid;
  logic [15:0] in_a, in_b;
  logic [31:0] in_prod;

  logic        in_ready, busy, done;
  logic [47:0] sum_ed;
  logic [31:0] max_ed;
  logic [15:0] err_count, sample_count;

  logic        in_ready32, busy32, done32;
  logic [31:0] sum_ed32;
  logic [31:0] max_ed32;
  logic [15:0] err_count32, sample_count32;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  approx_mul16_err_monitor #(.CNT_W(16), .SUM_W(48)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_prod(in_prod),
    .busy(busy), .done(done), .sum_ed(sum_ed), .max_ed(max_ed),
    .err_count(err_count), .sample_count(sample_count)
  );

  approx_mul16_err_monitor #(.CNT_W(16), .SUM_W(32)) dut32 (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_a(in_a), .in_b(in_b), .in_prod(in_prod),
    .busy(busy32), .done(done32), .sum_ed(sum_ed32), .max_ed(max_ed32),
    .err_count(err_count32), .sample_count(sample_count32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] len);
    start   = 1'b1;
    cfg_len = len;
    step();
    start   = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p);
    int w;
    w        = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_prod  = p;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    chk("ready_wait", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Count edges until done, check the latency, then check the single-cycle pulse.
  task automatic wait_done(input string tag, input int exp_edges);
    int n;
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_edges));
    chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic check_pulse_end(input string tag);
    step();
    chk({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    chk({tag, "_idle_not_busy"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic check_res(input string tag, input logic [63:0] s, input logic [31:0] m,
                           input logic [15:0] e, input logic [15:0] c);
    chk({tag, "_sum_ed"}, 64'(sum_ed), s);
    chk({tag, "_max_ed"}, 64'(max_ed), 64'(m));
    chk({tag, "_err_count"}, 64'(err_count), 64'(e));
    chk({tag, "_sample_count"}, 64'(sample_count), 64'(c));
  endtask

  initial begin
    int  n;
    logic seen;
    rst      = 1'b1;
    start    = 1'b0;
    cfg_len  = '0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_prod  = '0;
    step();
    step();
    check_res("reset", 64'd0, 32'd0, 16'd0, 16'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    step();

    // Exact products: ED is zero everywhere.
    start_run(16'd3);
    chk("exact_busy", {63'd0, busy}, 64'd1);
    send(16'd3, 16'd5, 32'd15);
    send(16'd0, 16'd7, 32'd0);
    send(16'd255, 16'd255, 32'd65025);
    wait_done("exact", 2);
    check_res("exact", 64'd0, 32'd0, 16'd0, 16'd3);
    check_pulse_end("exact");

    // 0xFFFF^2 = 0xFFFE0001; ED 1 and ED 0xFFFFFFFF.
    start_run(16'd2);
    send(16'hFFFF, 16'hFFFF, 32'hFFFE0000);
    send(16'h0000, 16'h0000, 32'hFFFFFFFF);
    wait_done("mixed", 2);
    check_res("mixed", 64'h1_0000_0000, 32'hFFFFFFFF, 16'd2, 16'd2);
    check_pulse_end("mixed");
    check_res("mixed_held", 64'h1_0000_0000, 32'hFFFFFFFF, 16'd2, 16'd2);

    // Two EDs of 0xFFFE0001 overflow a 32-bit accumulator.
    start_run(16'd2);
    send(16'hFFFF, 16'hFFFF, 32'h0);
    send(16'hFFFF, 16'hFFFF, 32'h0);
    wait_done("sat", 2);
    chk("sat32_sum_ed", 64'(sum_ed32), 64'hFFFFFFFF);
    chk("sat32_max_ed", 64'(max_ed32), 64'hFFFE0001);
    chk("sat32_err_count", 64'(err_count32), 64'd2);
    check_res("sat48", 64'h1_FFFC_0002, 32'hFFFE0001, 16'd2, 16'd2);
    check_pulse_end("sat");

    // Back-to-back reference: EDs 0, 1, 4, 6.
    start_run(16'd4);
    send(16'd3, 16'd5, 32'd15);
    send(16'h0010, 16'h0010, 32'h000000FF);
    send(16'h1234, 16'h0001, 32'h00001230);
    send(16'd2, 16'd3, 32'd0);
    wait_done("b2b", 2);
    check_res("b2b", 64'd11, 32'd6, 16'd3, 16'd4);
    check_pulse_end("b2b");

    // Same samples with gaps and a stray start while running.
    start_run(16'd4);
    step();
    send(16'd3, 16'd5, 32'd15);
    step();
    step();
    start   = 1'b1;
    cfg_len = 16'd1;
    step();
    start   = 1'b0;
    chk("gap_busy_after_start", {63'd0, busy}, 64'd1);
    send(16'h0010, 16'h0010, 32'h000000FF);
    step();
    send(16'h1234, 16'h0001, 32'h00001230);
    step();
    step();
    step();
    send(16'd2, 16'd3, 32'd0);
    wait_done("gap", 2);
    check_res("gap", 64'd11, 32'd6, 16'd3, 16'd4);
    check_pulse_end("gap");

    // Zero length with in_valid held high through IDLE and RUN.
    in_valid = 1'b1;
    in_a     = 16'd9;
    in_b     = 16'd9;
    in_prod  = 32'd0;
    step();
    start_run(16'd0);
    n    = 0;
    seen = 1'b0;
    while (!done && n < 20) begin
      if (in_ready) seen = 1'b1;
      step();
      n++;
    end
    chk("zero_latency", 64'(n), 64'd3);
    chk("zero_ready_never", {63'd0, seen}, 64'd0);
    check_res("zero", 64'd0, 32'd0, 16'd0, 16'd0);
    in_valid = 1'b0;
    check_pulse_end("zero");

    // Abort after two accepted samples.
    start_run(16'd4);
    send(16'd2, 16'd3, 32'd0);
    send(16'h1234, 16'h0001, 32'h00001230);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_res("abort", 64'd0, 32'd0, 16'd0, 16'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) seen = 1'b1;
      step();
    end
    chk("abort_no_done", {63'd0, seen}, 64'd0);
    check_res("abort_quiet", 64'd0, 32'd0, 16'd0, 16'd0);

    // Fresh run after abort proves the FSM returned to IDLE.
    start_run(16'd1);
    send(16'hFFFF, 16'hFFFF, 32'hFFFE0000);
    wait_done("after_abort", 2);
    check_res("after_abort", 64'd1, 32'd1, 16'd1, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
